// File: rtl/execute_button_shaper_if.sv
// execute_button_shaper_if: raw button input and shaped execute outputs
interface execute_button_shaper_if #(
    parameter int COUNT_W = 8
);
    logic               rawButton;
    logic               executePulse;
    logic               buttonHeld;
    logic               busy;
    logic [COUNT_W-1:0] pressCount;

    modport master (
        output rawButton,
        input  executePulse, buttonHeld, busy, pressCount
    );

    modport slave (
        input  rawButton,
        output executePulse, buttonHeld, busy, pressCount
    );
endinterface

// File: rtl/execute_button_shaper.sv
// execute_button_shaper: synchronise, debounce and pulse-shape the execute pushbutton
module execute_button_shaper #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int COUNT_W         = 8
) (
    input logic                    Clk,
    input logic                    Rst,
    execute_button_shaper_if.slave bus
);
    localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, ARM, FIRE, HELD, DISARM} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_q, s1_d, s2_q, s2_d;
    logic               pulse_q, pulse_d, held_q, held_d, busy_q, busy_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               pressed;

    assign pressed          = s2_q ^ ACTIVE_LOW;
    assign bus.executePulse = pulse_q;
    assign bus.buttonHeld   = held_q;
    assign bus.busy         = busy_q;
    assign bus.pressCount   = count_q;

    // Next-state, debounce counting and state-decoded outputs (registered one cycle later)
    always_comb begin
        s1_d    = bus.rawButton;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q + COUNT_W'(state_q == FIRE);
        pulse_d = state_q == FIRE;
        held_d  = state_q inside {FIRE, HELD, DISARM};
        busy_d  = state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = ARM;
                    cnt_d   = ONE;
                end
            end
            ARM: begin
                if (!pressed)             state_d = IDLE;
                else if (cnt_q == D_LAST) state_d = FIRE;
                else                      cnt_d   = cnt_q + ONE;
            end
            FIRE: state_d = HELD;
            HELD: begin
                if (!pressed) begin
                    state_d = DISARM;
                    cnt_d   = ONE;
                end
            end
            DISARM: begin
                if (pressed)              state_d = HELD;
                else if (cnt_q == D_LAST) state_d = IDLE;
                else                      cnt_d   = cnt_q + ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; synchronisers reset to the released level so reset never looks like a press
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_q    <= ACTIVE_LOW;
            s2_q    <= ACTIVE_LOW;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_execute_button_shaper.sv
// tb_execute_button_shaper: randomized scoreboard bench against a run-length reference model
module tb_execute_button_shaper;
    localparam int DB = 2;
    localparam bit AL = 1'b0;
    localparam int CW = 8;

    typedef struct packed {
        logic          pulse;
        logic          held;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    bit   sr[$];
    bit   mp[$];

    always #5 Clk = ~Clk;

    execute_button_shaper_if #(.COUNT_W(CW)) bus ();

    execute_button_shaper #(
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW     (AL),
        .COUNT_W        (CW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit val(input int i);
        return (i < mp.size()) ? mp[i] : 1'b0;
    endfunction

    function automatic bit zrun(input int m);
        for (int i = m; i <= m + DB; i++) if (val(i)) return 1'b0;
        return 1'b1;
    endfunction

    // Pressed level seen by the debouncer at edge e is the raw level two edges earlier.
    // A press is a run of DB+1 pressed samples while released; a release is a run of DB+1
    // released samples starting at least two edges after the press is accepted.
    task automatic model_push(input int L);
        int t, n, j, f, m;
        bit ok;
        bit pu[], he[], bu[];
        logic [CW-1:0] c;
        exp_t x;
        mp = {};
        mp.push_back(1'b0);
        mp.push_back(1'b0);
        foreach (sr[i]) mp.push_back(sr[i]);
        pu = new[L];
        he = new[L];
        bu = new[L];
        t = 0;
        while (t < L) begin
            n = t;
            while (n < L && !val(n)) n++;
            if (n >= L) break;
            ok = 1'b1;
            for (j = n + 1; j <= n + DB; j++) if (!val(j)) begin ok = 1'b0; break; end
            if (!ok) begin
                for (int e = n + 1; e <= j && e < L; e++) bu[e] = 1'b1;
                t = j + 1;
                continue;
            end
            f = n + DB;
            if (f + 1 < L) pu[f + 1] = 1'b1;
            m = f + 2;
            while (!zrun(m)) m++;
            for (int e = n + 1; e <= m + DB && e < L; e++) bu[e] = 1'b1;
            for (int e = f + 1; e <= m + DB && e < L; e++) he[e] = 1'b1;
            t = m + DB + 1;
        end
        c = '0;
        for (int e = 0; e < L; e++) begin
            if (pu[e]) c = c + 1'b1;
            x = '{pulse: pu[e], held: he[e], busy: bu[e], cnt: c};
            q.push_back(x);
        end
    endtask

    task automatic add(input bit v, input int n);
        repeat (n) sr.push_back(v);
    endtask

    task automatic run_seg();
        int L;
        L = sr.size();
        model_push(L);
        @(negedge Clk);
        bus.rawButton = sr[0] ^ AL;
        Rst = 1'b1;
        for (int k = 1; k < L; k++) begin
            @(negedge Clk);
            bus.rawButton = sr[k] ^ AL;
        end
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("async_reset", 64'({bus.executePulse, bus.buttonHeld, bus.busy, bus.pressCount}), 64'd0);
        check("queue_drained", 64'(q.size()), 64'd0);
        q  = {};
        sr = {};
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        exp_t x;
        #1;
        if (Rst) begin
            if (q.size() == 0) check("queue_underflow", 64'(q.size()), 64'd1);
            else begin
                x = q.pop_front();
                check("outputs", 64'({bus.executePulse, bus.buttonHeld, bus.busy, bus.pressCount}), 64'(x));
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL timeout at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.rawButton = AL;
        #2 Rst = 1'b0;
        @(posedge Clk);
        #1;
        check("reset_state", 64'({bus.executePulse, bus.buttonHeld, bus.busy, bus.pressCount}), 64'd0);
        @(negedge Clk);
        add(0, 22);
        run_seg();
        repeat (20) begin
            add(1, 4);
            add(0, 3);
        end
        add(0, 6);
        run_seg();
        repeat (5) begin
            add(1, 4);
            add(0, 2);
        end
        add(0, 6);
        run_seg();
        add(1, 2);
        add(0, 5);
        add(1, 3);
        add(0, 6);
        run_seg();
        add(1, 50);
        add(0, 10);
        run_seg();
        add(1, 6);
        add(0, 1);
        add(1, 1);
        add(0, 8);
        run_seg();
        add(1, 4);
        run_seg();
        add(1, 10);
        add(0, 8);
        run_seg();
        add(1, 5);
        run_seg();
        add(1, 6);
        run_seg();
        add(1, 9);
        add(0, 6);
        run_seg();
        repeat (12) begin
            while (sr.size() < 40) begin
                add(1, $urandom_range(1, 6));
                add(0, $urandom_range(1, 6));
            end
            if ($urandom_range(0, 1) == 1) add(1, $urandom_range(1, 5));
            run_seg();
        end
        repeat (256) begin
            add(1, DB + 1);
            add(0, DB + 1);
        end
        add(0, 6);
        run_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
